fetch_redirect_unit: RTL and testbench



---
 rtl/fetch_redirect_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_redirect_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit.sv
// Fetch-side PC owner: turns redirect/stall/flush decisions into instruction-memory
// requests and the IF/ID register, buffering one in-flight fetch across stalls.
module fetch_redirect_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PC_Mux,
  input  logic [1:0]       redirect_sel,
  input  logic             reset_IF_ID,
  input  logic             reset_ID_EX,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [XLEN-1:0]  jalr_target,
  input  logic [XLEN-1:0]  jal_target,
  input  logic             stall,
  output logic             imem_en,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [XLEN-1:0]  pc,
  output logic [31:0]      if_id_instr,
  output logic [XLEN-1:0]  if_id_pc,
  output logic             if_id_valid,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] redirect_count,
  output logic             sel_error
);

  typedef enum logic [0:0] {RUN, STALL} state_t;

  state_t            state_reg;
  logic [XLEN-1:0]   pc_reg;
  logic              inflight_reg;
  logic [XLEN-1:0]   inflight_pc_reg;
  logic              skid_valid_reg;
  logic [31:0]       skid_instr_reg;
  logic [XLEN-1:0]   skid_pc_reg;
  logic [31:0]       if_id_instr_reg;
  logic [XLEN-1:0]   if_id_pc_reg;
  logic              if_id_valid_reg;
  logic [CNT_W-1:0]  redirect_count_reg;
  logic              sel_error_reg;

  logic              redirect_taken;
  logic              load_skid;
  logic [XLEN-1:0]   target_next;

  assign redirect_taken = PC_Mux && (redirect_sel != 2'b11);
  // A valid skid entry only exists after a stall, so the STALL state qualifies it.
  assign load_skid      = (state_reg == STALL) && skid_valid_reg;

  always_comb begin
    target_next = pc_reg;
    case (redirect_sel)
      2'b00:   target_next = branch_target;
      2'b01:   target_next = jalr_target & ~XLEN'(1);
      2'b10:   target_next = jal_target;
      default: target_next = pc_reg;
    endcase
  end

  assign imem_en        = !reset && !redirect_taken && !stall;
  assign imem_addr      = pc_reg;
  assign pc             = pc_reg;
  assign id_ex_flush    = !reset && reset_ID_EX && redirect_taken;
  assign if_id_instr    = if_id_instr_reg;
  assign if_id_pc       = if_id_pc_reg;
  assign if_id_valid    = if_id_valid_reg;
  assign redirect_count = redirect_count_reg;
  assign sel_error      = sel_error_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= RUN;
      pc_reg             <= RESET_PC;
      inflight_reg       <= 1'b0;
      inflight_pc_reg    <= '0;
      skid_valid_reg     <= 1'b0;
      skid_instr_reg     <= NOP_INSTR;
      skid_pc_reg        <= '0;
      if_id_valid_reg    <= 1'b0;
      if_id_instr_reg    <= NOP_INSTR;
      if_id_pc_reg       <= '0;
      redirect_count_reg <= '0;
      sel_error_reg      <= 1'b0;
    end else begin
      if (PC_Mux && (redirect_sel == 2'b11))
        sel_error_reg <= 1'b1;

      if (redirect_taken) begin
        // The fetch in flight and any skid entry belong to the wrong path.
        pc_reg         <= target_next;
        inflight_reg   <= 1'b0;
        skid_valid_reg <= 1'b0;
        state_reg      <= RUN;
        if (redirect_count_reg != '1)
          redirect_count_reg <= redirect_count_reg + CNT_W'(1);
        if (reset_IF_ID) begin
          if_id_valid_reg <= 1'b0;
          if_id_instr_reg <= NOP_INSTR;
        end
      end else if (stall) begin
        if (inflight_reg) begin
          skid_instr_reg <= imem_rdata;
          skid_pc_reg    <= inflight_pc_reg;
          skid_valid_reg <= 1'b1;
        end
        inflight_reg <= 1'b0;
        state_reg    <= STALL;
        if (reset_IF_ID) begin
          if_id_valid_reg <= 1'b0;
          if_id_instr_reg <= NOP_INSTR;
        end
      end else begin
        if (reset_IF_ID) begin
          if_id_valid_reg <= 1'b0;
          if_id_instr_reg <= NOP_INSTR;
        end else if (load_skid) begin
          if_id_valid_reg <= 1'b1;
          if_id_instr_reg <= skid_instr_reg;
          if_id_pc_reg    <= skid_pc_reg;
        end else if (inflight_reg) begin
          if_id_valid_reg <= 1'b1;
          if_id_instr_reg <= imem_rdata;
          if_id_pc_reg    <= inflight_pc_reg;
        end else begin
          if_id_valid_reg <= 1'b0;
          if_id_instr_reg <= NOP_INSTR;
        end
        skid_valid_reg  <= 1'b0;
        inflight_reg    <= 1'b1;
        inflight_pc_reg <= pc_reg;
        pc_reg          <= pc_reg + XLEN'(4);
        state_reg       <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit; the memory model returns its address as data.
module tb_fetch_redirect_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             PC_Mux;
  logic [1:0]       redirect_sel;
  logic             reset_IF_ID;
  logic             reset_ID_EX;
  logic [XLEN-1:0]  branch_target;
  logic [XLEN-1:0]  jalr_target;
  logic [XLEN-1:0]  jal_target;
  logic             stall;
  logic             imem_en;
  logic [XLEN-1:0]  imem_addr;
  logic [31:0]      imem_rdata = 32'h0;
  logic [XLEN-1:0]  pc;
  logic [31:0]      if_id_instr;
  logic [XLEN-1:0]  if_id_pc;
  logic             if_id_valid;
  logic             id_ex_flush;
  logic [CNT_W-1:0] redirect_count;
  logic             sel_error;

  int passed = 0;
  int total  = 0;

  fetch_redirect_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .PC_Mux(PC_Mux), .redirect_sel(redirect_sel),
    .reset_IF_ID(reset_IF_ID), .reset_ID_EX(reset_ID_EX),
    .branch_target(branch_target), .jalr_target(jalr_target), .jal_target(jal_target),
    .stall(stall), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .id_ex_flush(id_ex_flush), .redirect_count(redirect_count), .sel_error(sel_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= imem_addr;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; PC_Mux = 1'b0; redirect_sel = 2'b11; reset_IF_ID = 1'b0;
    reset_ID_EX = 1'b0; stall = 1'b0;
    branch_target = 32'h0; jalr_target = 32'h0; jal_target = 32'h0;
    tick; tick; sample;
    chk("rst_en",    32'(imem_en), 32'h0);
    chk("rst_pc",    pc, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_instr", if_id_instr, 32'h0000_0013);
    chk("rst_cnt",   32'(redirect_count), 32'h0);
    chk("rst_err",   32'(sel_error), 32'h0);
    tick; reset = 1'b0; sample;                      // cycle 0
    chk("c0_en", 32'(imem_en), 32'h1);
    chk("c0_addr", imem_addr, 32'h0);
    tick; sample;                                    // cycle 1
    chk("c1_addr", imem_addr, 32'h4);
    chk("c1_valid", 32'(if_id_valid), 32'h0);
    tick; sample;                                    // cycle 2
    chk("c2_addr", imem_addr, 32'h8);
    chk("c2_valid", 32'(if_id_valid), 32'h1);
    chk("c2_ifpc", if_id_pc, 32'h0);
    chk("c2_instr", if_id_instr, 32'h0);
    tick; sample;                                    // cycle 3
    chk("c3_ifpc", if_id_pc, 32'h4);
    chk("c3_instr", if_id_instr, 32'h4);
    tick; sample;                                    // cycle 4
    chk("c4_addr", imem_addr, 32'h10);
    tick;                                            // cycle 5: branch with both flushes
    PC_Mux = 1'b1; redirect_sel = 2'b00; branch_target = 32'h100;
    reset_IF_ID = 1'b1; reset_ID_EX = 1'b1;
    sample;
    chk("c5_flush", 32'(id_ex_flush), 32'h1);
    chk("c5_en", 32'(imem_en), 32'h0);
    chk("c5_ifpc", if_id_pc, 32'hC);
    tick;
    PC_Mux = 1'b0; redirect_sel = 2'b11; reset_IF_ID = 1'b0; reset_ID_EX = 1'b0;
    sample;                                          // cycle 6
    chk("c6_flush", 32'(id_ex_flush), 32'h0);
    chk("c6_en", 32'(imem_en), 32'h1);
    chk("c6_addr", imem_addr, 32'h100);
    chk("c6_valid", 32'(if_id_valid), 32'h0);
    chk("c6_cnt", 32'(redirect_count), 32'h1);
    tick; sample;                                    // cycle 7
    chk("c7_valid", 32'(if_id_valid), 32'h0);
    chk("c7_addr", imem_addr, 32'h104);
    tick; sample;                                    // cycle 8
    chk("c8_valid", 32'(if_id_valid), 32'h1);
    chk("c8_ifpc", if_id_pc, 32'h100);
    chk("c8_instr", if_id_instr, 32'h100);
    tick; sample;                                    // cycle 9
    chk("c9_addr", imem_addr, 32'h10C);
    tick; stall = 1'b1; sample;                      // cycles 10-12: stall with 0x10C in flight
    chk("c10_en", 32'(imem_en), 32'h0);
    chk("c10_ifpc", if_id_pc, 32'h108);
    tick; sample;
    chk("c11_ifpc", if_id_pc, 32'h108);
    tick; sample;
    chk("c12_ifpc", if_id_pc, 32'h108);
    chk("c12_pc", pc, 32'h110);
    tick; stall = 1'b0; sample;                      // cycle 13
    chk("c13_en", 32'(imem_en), 32'h1);
    chk("c13_addr", imem_addr, 32'h110);
    chk("c13_ifpc", if_id_pc, 32'h108);
    tick; sample;                                    // cycle 14: skid enters IF/ID
    chk("c14_ifpc", if_id_pc, 32'h10C);
    chk("c14_instr", if_id_instr, 32'h10C);
    chk("c14_addr", imem_addr, 32'h114);
    tick; sample;                                    // cycle 15
    chk("c15_ifpc", if_id_pc, 32'h110);
    chk("c15_instr", if_id_instr, 32'h110);
    tick; stall = 1'b1; sample;                      // cycle 16: skid captures 0x118
    chk("c16_ifpc", if_id_pc, 32'h114);
    tick;                                            // cycle 17: JAL during stall
    PC_Mux = 1'b1; redirect_sel = 2'b10; jal_target = 32'h400;
    sample;
    chk("c17_en", 32'(imem_en), 32'h0);
    chk("c17_flush", 32'(id_ex_flush), 32'h0);
    tick; stall = 1'b0; PC_Mux = 1'b0; redirect_sel = 2'b11; sample;   // cycle 18
    chk("c18_en", 32'(imem_en), 32'h1);
    chk("c18_addr", imem_addr, 32'h400);
    chk("c18_ifpc", if_id_pc, 32'h114);
    chk("c18_cnt", 32'(redirect_count), 32'h2);
    tick; sample;                                    // cycle 19: dropped skid must not appear
    chk("c19_valid", 32'(if_id_valid), 32'h0);
    chk("c19_addr", imem_addr, 32'h404);
    tick; sample;                                    // cycle 20
    chk("c20_valid", 32'(if_id_valid), 32'h1);
    chk("c20_ifpc", if_id_pc, 32'h400);
    tick;                                            // cycle 21: JALR, odd target
    PC_Mux = 1'b1; redirect_sel = 2'b01; jalr_target = 32'h2001; branch_target = 32'h5550;
    sample;
    chk("c21_en", 32'(imem_en), 32'h0);
    tick; redirect_sel = 2'b10; jal_target = 32'h3000; sample;          // cycle 22: JAL
    chk("c22_pc", pc, 32'h2000);
    chk("c22_cnt", 32'(redirect_count), 32'h3);
    tick; redirect_sel = 2'b11; reset_ID_EX = 1'b1; sample;             // cycle 23: bad select
    chk("c23_pc", pc, 32'h3000);
    chk("c23_cnt", 32'(redirect_count), 32'h4);
    chk("c23_en", 32'(imem_en), 32'h1);
    chk("c23_flush", 32'(id_ex_flush), 32'h0);
    chk("c23_err", 32'(sel_error), 32'h0);
    tick; PC_Mux = 1'b0; reset_ID_EX = 1'b0; sample;                    // cycle 24
    chk("c24_err", 32'(sel_error), 32'h1);
    chk("c24_pc", pc, 32'h3004);
    chk("c24_cnt", 32'(redirect_count), 32'h4);
    tick; reset_IF_ID = 1'b1; sample;                                   // cycle 25: squash only
    chk("c25_ifpc", if_id_pc, 32'h3000);
    chk("c25_addr", imem_addr, 32'h3008);
    tick; reset_IF_ID = 1'b0; sample;                                   // cycle 26
    chk("c26_valid", 32'(if_id_valid), 32'h0);
    chk("c26_addr", imem_addr, 32'h300C);
    chk("c26_err", 32'(sel_error), 32'h1);
    tick; sample;                                                       // cycle 27
    chk("c27_ifpc", if_id_pc, 32'h3008);
    chk("c27_valid", 32'(if_id_valid), 32'h1);
    // Back-to-back branches drive the counter into saturation.
    for (int i = 1; i <= 14; i++) begin
      int e;
      tick; PC_Mux = 1'b1; redirect_sel = 2'b00; branch_target = 32'hFFFF_FFFC; sample;
      e = 4 + i - 1;
      if (e > 15) e = 15;
      chk("sat_cnt", 32'(redirect_count), 32'(e));
    end
    tick; PC_Mux = 1'b0; redirect_sel = 2'b11; sample;
    chk("sat_final", 32'(redirect_count), 32'hF);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick; sample;
    chk("wrap_addr1", imem_addr, 32'h0);
    tick; stall = 1'b1; sample;
    chk("ms_en", 32'(imem_en), 32'h0);
    tick; reset = 1'b1; PC_Mux = 1'b1; redirect_sel = 2'b00; reset_ID_EX = 1'b1; sample;
    chk("rs_en", 32'(imem_en), 32'h0);
    chk("rs_flush", 32'(id_ex_flush), 32'h0);
    tick; reset = 1'b0; stall = 1'b0; PC_Mux = 1'b0; redirect_sel = 2'b11; reset_ID_EX = 1'b0;
    sample;
    chk("r0_pc", pc, 32'h0);
    chk("r0_cnt", 32'(redirect_count), 32'h0);
    chk("r0_err", 32'(sel_error), 32'h0);
    chk("r0_valid", 32'(if_id_valid), 32'h0);
    chk("r0_en", 32'(imem_en), 32'h1);
    tick; sample;
    chk("r1_valid", 32'(if_id_valid), 32'h0);
    chk("r1_addr", imem_addr, 32'h4);
    tick; sample;
    chk("r2_valid", 32'(if_id_valid), 32'h1);
    chk("r2_ifpc", if_id_pc, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
